dmem_arbiter: RTL and testbench
===============================

// Module: dmem_arbiter
// PURPOSE
//  Shares the single data memory (1 write port w/ byte enables, 1 sync read port, 1-cycle read latency)
//  between two requesters: port 0 = core load/store unit, port 1 = loader/debug master.
//  Per-cycle grant, valid/ready request handshake, read responses routed back to the owning port.
//  Sits between the LSU/loader and the data memory; the memory itself is unchanged.
// PARAMETERS
//  ADDR_W    15  word-address width of the data memory (32768 words)
//  MAX_WAIT  8   consecutive lost cycles before a waiting port is forced to win (anti-starvation)
// PORTS
//  clk             in   1       clock, all state on posedge
//  rst_n           in   1       async active-low reset
//  reqValid[i]     in   1       request i valid (i = 0,1)
//  reqWrite[i]     in   1       1 = store, 0 = load
//  reqAddr[i]      in   32      byte address; word = reqAddr[ADDR_W+1:2]
//  reqWData[i]     in   32      store data, already lane-aligned
//  reqByteEn[i]    in   4       store byte enables; ignored for loads
//  reqReady[i]     out  1       request i accepted this cycle
//  rspValid[i]     out  1       load data for port i valid this cycle
//  rspData         out  32      load data (shared by both ports; qualify with rspValid)
//  memWEnable      out  4       to memory byte write enables
//  memWAddr        out  ADDR_W  to memory write word address
//  memRAddr        out  ADDR_W  to memory read word address
//  memRowAddr      out  32      to memory full byte address (for memory trace)
//  memWData        out  32      to memory write data
//  memRData        in   32      from memory, valid 1 cycle after memRAddr is sampled
// BEHAVIOUR
//  - One grant per cycle; grant is combinational from reqValid + arbiter state; granted port gets reqReady=1.
//  - Accept = reqValid & reqReady. Store accepted at cycle N: memWEnable = reqByteEn, memWAddr/memWData driven in N.
//  - Load accepted at N: memRAddr driven in N; rspValid[owner]=1 and rspData=memRData in N+1.
//  - Back-to-back loads fully pipelined (1 accept/cycle); owner kept in registered rdOwner/rdPending.
//  - No request: memWEnable=0, memRAddr/memWAddr hold last value (don't-care), no response next cycle.
//  - Store with reqByteEn=0 is accepted, writes nothing.
//  - Requester must hold reqValid and fields stable until accepted.
//  - Default policy: port 0 priority. wait1 counter increments each cycle port 1 is valid and not granted,
//    clears on port-1 accept or when port-1 valid drops; wait1 == MAX_WAIT-1 -> port 1 wins next contested cycle.
//    Counter saturates; symmetric wait0 exists only in round-robin mode.
//  - Reset (rst_n=0, async): rdPending=0, rdOwner=0, wait counters=0, rrLast=1; outputs forced
//    reqReady=0, rspValid=0, memWEnable=0, rspData=0, addresses/data=0 while reset asserted.
//  - Reset mid-load: pending response dropped; no rspValid after release.
// CONFIGURATION
//  DMEM_ARB_RR_EN defined: round-robin; on contest, port != rrLast wins; rrLast updates on each accept;
//    starvation counters unused (tied 0). Not defined: fixed priority + MAX_WAIT anti-starvation as above.
// STRUCTURE
//  - Package MemoryTypes: MemAddr-compatible word address, BasicData, ByteEn (logic[3:0]), typedef DMemReq
//    struct {write, addr, wdata, byteEn}, localparam DMEM_PORTS=2, function byteToWordAddr().
//  - Sub-module dmem_arb_grant: grant logic + rrLast/wait counters; top holds read-owner pipe and muxing.
// TESTING
//  1. Reset: rst_n=0 with both reqValid=1 -> reqReady=00, memWEnable=0; release -> grant begins next edge.
//  2. P0 store addr 0x100 data 0xDEADBEEF byteEn 0xF, then P0 load 0x100 -> rspValid[0] one cycle after accept,
//     rspData=0xDEADBEEF.
//  3. P1 store 0x104 byteEn 0x3 data 0x1234ABCD over 0xFFFFFFFF -> load returns 0xFFFFABCD.
//  4. Both valid continuously (fixed prio, MAX_WAIT=8): P1 granted exactly on every 8th contested cycle;
//     with DMEM_ARB_RR_EN grants alternate 0,1,0,1.
//  5. Loads P0@0x0, P1@0x4, P0@0x8 back-to-back -> rspValid pattern 01,10,01 with matching data, no bubbles.
//  6. Assert rst_n=0 the cycle after a load accept -> no rspValid after reset release.

Source files
------------

// File: rtl/dmem_arbiter_pkg.sv
// dmem_arbiter_pkg: data-memory types, request struct and address helper shared by the arbiter files
package dmem_arbiter_pkg;
  localparam int DMEM_ADDR_W = 15;
  localparam int DMEM_PORTS = 2;
  typedef logic [DMEM_ADDR_W-1:0] MemAddr;
  typedef logic [31:0] BasicData;
  typedef logic [3:0] ByteEn;
  typedef struct packed {
    logic     write;
    BasicData addr;
    BasicData wdata;
    ByteEn    byteEn;
  } DMemReq;
  function automatic BasicData byteToWordAddr(input BasicData a);
    return {2'b00, a[31:2]};
  endfunction
endpackage

// File: rtl/dmem_arbiter_grant.sv
// dmem_arbiter_grant: per-cycle grant between the two data-memory requesters
// DMEM_ARB_RR_EN selects round-robin; otherwise port 0 priority with port-1 anti-starvation
module dmem_arbiter_grant
  import dmem_arbiter_pkg::*;
#(
  parameter int MAX_WAIT = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [DMEM_PORTS-1:0] i_valid,
  output logic                  o_gnt_valid,
  output logic                  o_gnt_idx
);
  logic w_contest, w_p1_wins;
  assign w_contest = &i_valid;
`ifdef DMEM_ARB_RR_EN
  logic r_rr_last;
  assign w_p1_wins = ~r_rr_last;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) r_rr_last <= 1'b1;
    else if (o_gnt_valid) r_rr_last <= o_gnt_idx;
`else
  localparam int CW = MAX_WAIT > 2 ? $clog2(MAX_WAIT) : 1;
  logic [CW-1:0] r_wait1;
  assign w_p1_wins = r_wait1 == CW'(MAX_WAIT - 1);
  // o_gnt_idx high implies port 1 was valid and won, so the wait is over
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) r_wait1 <= '0;
    else r_wait1 <= (!i_valid[1] || o_gnt_idx) ? '0 :
                    (r_wait1 == CW'(MAX_WAIT - 1)) ? r_wait1 : r_wait1 + CW'(1);
`endif
  assign o_gnt_idx   = w_contest ? w_p1_wins : i_valid[1];
  assign o_gnt_valid = rst_n & (|i_valid);
endmodule

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares the single data memory between the LSU (port 0) and the loader/debug master (port 1)
// DMEM_ARB_RR_EN selects round-robin arbitration instead of fixed priority with anti-starvation
module dmem_arbiter
  import dmem_arbiter_pkg::*;
#(
  parameter int ADDR_W   = DMEM_ADDR_W,
  parameter int MAX_WAIT = 8
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [DMEM_PORTS-1:0]      reqValid,
  input  logic [DMEM_PORTS-1:0]      reqWrite,
  input  logic [DMEM_PORTS-1:0][31:0] reqAddr,
  input  logic [DMEM_PORTS-1:0][31:0] reqWData,
  input  logic [DMEM_PORTS-1:0][3:0] reqByteEn,
  output logic [DMEM_PORTS-1:0]      reqReady,
  output logic [DMEM_PORTS-1:0]      rspValid,
  output logic [31:0]                rspData,
  output logic [3:0]                 memWEnable,
  output logic [ADDR_W-1:0]          memWAddr,
  output logic [ADDR_W-1:0]          memRAddr,
  output logic [31:0]                memRowAddr,
  output logic [31:0]                memWData,
  input  logic [31:0]                memRData
);
  DMemReq            w_req;
  logic              w_gnt_valid, w_gnt_idx, w_st, w_ld;
  logic [ADDR_W-1:0] w_word, r_waddr, r_raddr;
  logic              r_rd_pending, r_rd_owner;
  dmem_arbiter_grant #(.MAX_WAIT(MAX_WAIT)) u_grant (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_valid     (reqValid),
    .o_gnt_valid (w_gnt_valid),
    .o_gnt_idx   (w_gnt_idx)
  );
  assign w_req  = w_gnt_idx ? {reqWrite[1], reqAddr[1], reqWData[1], reqByteEn[1]}
                            : {reqWrite[0], reqAddr[0], reqWData[0], reqByteEn[0]};
  assign w_word = ADDR_W'(byteToWordAddr(w_req.addr));
  assign w_st   = w_gnt_valid & w_req.write;
  assign w_ld   = w_gnt_valid & ~w_req.write;
  // read owner travels one stage alongside the memory's read latency
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_rd_pending <= 1'b0;
      r_rd_owner   <= 1'b0;
      r_waddr      <= '0;
      r_raddr      <= '0;
    end else begin
      r_rd_pending <= w_ld;
      r_rd_owner   <= w_gnt_idx;
      if (w_st) r_waddr <= w_word;
      if (w_ld) r_raddr <= w_word;
    end
  assign reqReady   = {w_gnt_idx, ~w_gnt_idx} & {2{w_gnt_valid}};
  assign rspValid   = {r_rd_owner, ~r_rd_owner} & {2{r_rd_pending}};
  assign rspData    = r_rd_pending ? memRData : '0;
  assign memWEnable = w_st ? w_req.byteEn : 4'h0;
  assign memWAddr   = w_st ? w_word : r_waddr;
  assign memRAddr   = w_ld ? w_word : r_raddr;
  assign memRowAddr = w_gnt_valid ? w_req.addr : '0;
  assign memWData   = w_st ? w_req.wdata : '0;
endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: directed scenarios plus a randomized run against a spec-level arbitration/memory model
module tb_dmem_arbiter;
  localparam int MAX_WAIT = 8;
`ifdef DMEM_ARB_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif
  logic clk = 1'b0;
  logic rst_n;
  logic [1:0] reqValid, reqWrite, reqReady, rspValid;
  logic [1:0][31:0] reqAddr, reqWData;
  logic [1:0][3:0] reqByteEn;
  logic [31:0] rspData, memRowAddr, memWData, memRData;
  logic [3:0] memWEnable;
  logic [14:0] memWAddr, memRAddr;
  logic [31:0] mem [0:32767];
  logic [31:0] ref_mem [int];
  int n_cmp = 0;
  int n_bad = 0;

  dmem_arbiter #(.ADDR_W(15), .MAX_WAIT(MAX_WAIT)) dut (
    .clk(clk), .rst_n(rst_n), .reqValid(reqValid), .reqWrite(reqWrite), .reqAddr(reqAddr),
    .reqWData(reqWData), .reqByteEn(reqByteEn), .reqReady(reqReady), .rspValid(rspValid),
    .rspData(rspData), .memWEnable(memWEnable), .memWAddr(memWAddr), .memRAddr(memRAddr),
    .memRowAddr(memRowAddr), .memWData(memWData), .memRData(memRData)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    for (int b = 0; b < 4; b++)
      if (memWEnable[b]) mem[memWAddr][8*b +: 8] <= memWData[8*b +: 8];
    memRData <= mem[memRAddr];
  end

  initial begin
    #3000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  function automatic logic [31:0] ref_rd(input int w);
    return ref_mem.exists(w) ? ref_mem[w] : 32'h0;
  endfunction

  task automatic send(input int p, input logic w, input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
    int t = 0;
    @(negedge clk);
    reqValid = '0;
    reqWrite[p] = w; reqAddr[p] = a; reqWData[p] = d; reqByteEn[p] = be; reqValid[p] = 1'b1;
    #1;
    while (!reqReady[p] && t < 40) begin @(negedge clk); #1; t++; end
    if (!reqReady[p]) begin
      n_cmp++; n_bad++;
      $display("FAIL send_timeout port=%0d got_ready=%b exp=accept", p, reqReady);
    end
    @(posedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    reqValid = 2'b11; reqWrite = 2'b11; reqByteEn = '{4'hF, 4'hF};
    reqAddr = '{32'h80, 32'h40}; reqWData = '{32'h5555_5555, 32'hAAAA_AAAA};
    repeat (2) @(negedge clk);
    n_cmp++; if (reqReady !== 2'b00) begin n_bad++; $display("FAIL rst_ready got=%b exp=00", reqReady); end
    n_cmp++; if (memWEnable !== 4'h0) begin n_bad++; $display("FAIL rst_wen got=%h exp=0", memWEnable); end
    n_cmp++; if (rspValid !== 2'b00) begin n_bad++; $display("FAIL rst_rspvalid got=%b exp=00", rspValid); end
    n_cmp++; if (rspData !== 32'h0) begin n_bad++; $display("FAIL rst_rspdata got=%h exp=0", rspData); end
    n_cmp++; if ({memWAddr, memRAddr, memRowAddr, memWData} !== '0) begin
      n_bad++; $display("FAIL rst_memout got=%h/%h/%h/%h exp=0", memWAddr, memRAddr, memRowAddr, memWData);
    end
    reqWrite = 2'b00;
    rst_n = 1'b1;
    #1;
    n_cmp++; if (reqReady !== 2'b01) begin n_bad++; $display("FAIL rel_ready got=%b exp=01", reqReady); end
    n_cmp++; if (memRAddr !== 15'h10) begin n_bad++; $display("FAIL rel_raddr got=%h exp=10", memRAddr); end
    @(negedge clk);
    reqValid = 2'b00;
    n_cmp++; if (rspValid !== 2'b01) begin n_bad++; $display("FAIL rel_rsp got=%b exp=01", rspValid); end
  endtask

  task automatic test_store_load();
    send(0, 1'b1, 32'h100, 32'hDEAD_BEEF, 4'hF);
    send(0, 1'b0, 32'h100, 32'h0, 4'h0);
    @(negedge clk);
    reqValid = 2'b00;
    n_cmp++; if (rspValid !== 2'b01) begin n_bad++; $display("FAIL sl_rspvalid got=%b exp=01", rspValid); end
    n_cmp++; if (rspData !== 32'hDEAD_BEEF) begin n_bad++; $display("FAIL sl_rspdata got=%h exp=deadbeef", rspData); end
    @(negedge clk);
    n_cmp++; if (rspValid !== 2'b00) begin n_bad++; $display("FAIL sl_idle got=%b exp=00", rspValid); end
  endtask

  task automatic test_byte_enable();
    send(1, 1'b1, 32'h104, 32'hFFFF_FFFF, 4'hF);
    send(1, 1'b1, 32'h104, 32'h1234_ABCD, 4'h3);
    send(1, 1'b1, 32'h104, 32'h0000_0000, 4'h0);
    send(1, 1'b0, 32'h104, 32'h0, 4'h0);
    @(negedge clk);
    reqValid = 2'b00;
    n_cmp++; if (rspValid !== 2'b10) begin n_bad++; $display("FAIL be_rspvalid got=%b exp=10", rspValid); end
    n_cmp++; if (rspData !== 32'hFFFF_ABCD) begin n_bad++; $display("FAIL be_rspdata got=%h exp=ffffabcd", rspData); end
  endtask

  task automatic test_contest();
    logic [1:0] prev = 2'b00;
    logic [1:0] exp;
    @(negedge clk);
    reqWrite = 2'b00; reqAddr = '{32'h4, 32'h0}; reqValid = 2'b11;
    for (int k = 0; k < 24; k++) begin
      #1;
      exp = RR ? ((k % 2 == 1) ? 2'b10 : 2'b01) : ((k % MAX_WAIT == MAX_WAIT - 1) ? 2'b10 : 2'b01);
      n_cmp++; if (reqReady !== exp) begin n_bad++; $display("FAIL contest_grant k=%0d got=%b exp=%b", k, reqReady, exp); end
      if (k > 0) begin
        n_cmp++; if (rspValid !== prev) begin n_bad++; $display("FAIL contest_rsp k=%0d got=%b exp=%b", k, rspValid, prev); end
      end
      prev = exp;
      @(negedge clk);
    end
    reqValid = 2'b00;
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    logic [31:0] v [3];
    int pp [3] = '{0, 1, 0};
    for (int i = 0; i < 3; i++) begin
      v[i] = $urandom;
      send(pp[i], 1'b1, 32'(4 * i), v[i], 4'hF);
    end
    @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      if (i > 0) begin
        n_cmp++; if (rspValid !== (pp[i-1] == 1 ? 2'b10 : 2'b01)) begin
          n_bad++; $display("FAIL b2b_rspvalid i=%0d got=%b exp_port=%0d", i, rspValid, pp[i-1]);
        end
        n_cmp++; if (rspData !== v[i-1]) begin n_bad++; $display("FAIL b2b_rspdata i=%0d got=%h exp=%h", i, rspData, v[i-1]); end
      end
      reqValid = 2'b00;
      if (i < 3) begin
        reqWrite[pp[i]] = 1'b0; reqAddr[pp[i]] = 32'(4 * i); reqValid[pp[i]] = 1'b1;
        #1;
        n_cmp++; if (reqReady !== (pp[i] == 1 ? 2'b10 : 2'b01)) begin
          n_bad++; $display("FAIL b2b_ready i=%0d got=%b exp_port=%0d", i, reqReady, pp[i]);
        end
        n_cmp++; if (memRAddr !== 15'(i)) begin n_bad++; $display("FAIL b2b_raddr i=%0d got=%h exp=%h", i, memRAddr, i); end
      end
      @(negedge clk);
    end
  endtask

  task automatic test_reset_mid_load();
    send(0, 1'b0, 32'h100, 32'h0, 4'h0);
    #1;
    rst_n = 1'b0;
    #1;
    n_cmp++; if (rspValid !== 2'b00) begin n_bad++; $display("FAIL midrst_rsp got=%b exp=00", rspValid); end
    @(negedge clk);
    reqValid = 2'b00;
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      n_cmp++; if (rspValid !== 2'b00) begin n_bad++; $display("FAIL midrst_after k=%0d got=%b exp=00", k, rspValid); end
    end
  endtask

  task automatic test_random();
    logic pend [2] = '{1'b0, 1'b0};
    logic pw [2];
    logic [31:0] pa [2];
    logic [31:0] pd [2];
    logic [3:0] pb [2];
    int lost1 = 0;
    logic last = 1'b1;
    logic [1:0] exp_rv = 2'b00;
    logic [31:0] exp_rd = 32'h0;
    logic gv, gi;
    logic [1:0] exp_rdy;
    logic [31:0] tmp;
    int w;
    for (int c = 0; c < 400; c++) begin
      n_cmp++; if (rspValid !== exp_rv) begin n_bad++; $display("FAIL rnd_rspvalid c=%0d got=%b exp=%b", c, rspValid, exp_rv); end
      if (exp_rv != 2'b00) begin
        n_cmp++; if (rspData !== exp_rd) begin n_bad++; $display("FAIL rnd_rspdata c=%0d got=%h exp=%h", c, rspData, exp_rd); end
      end
      for (int p = 0; p < 2; p++)
        if (!pend[p] && $urandom_range(0, 99) < (p == 0 ? 92 : 60)) begin
          pend[p] = 1'b1;
          pw[p] = 1'($urandom_range(0, 1));
          pa[p] = ($urandom & 32'hFFFE_0000) | ((32'd256 + $urandom_range(0, 15)) << 2) | ($urandom & 32'h3);
          pd[p] = $urandom;
          pb[p] = 4'($urandom);
        end
      for (int p = 0; p < 2; p++) begin
        reqValid[p] = pend[p]; reqWrite[p] = pw[p]; reqAddr[p] = pa[p]; reqWData[p] = pd[p]; reqByteEn[p] = pb[p];
      end
      #1;
      gv = pend[0] | pend[1];
      gi = (pend[0] & pend[1]) ? (RR ? ~last : (lost1 == MAX_WAIT - 1)) : pend[1];
      exp_rdy = gv ? (gi ? 2'b10 : 2'b01) : 2'b00;
      n_cmp++; if (reqReady !== exp_rdy) begin n_bad++; $display("FAIL rnd_ready c=%0d got=%b exp=%b", c, reqReady, exp_rdy); end
      exp_rv = 2'b00;
      if (gv) begin
        w = int'(pa[gi][16:2]);
        n_cmp++; if (memRowAddr !== pa[gi]) begin n_bad++; $display("FAIL rnd_rowaddr c=%0d got=%h exp=%h", c, memRowAddr, pa[gi]); end
        if (pw[gi]) begin
          n_cmp++; if ({memWEnable, memWAddr, memWData} !== {pb[gi], 15'(w), pd[gi]}) begin
            n_bad++; $display("FAIL rnd_store c=%0d got=%h/%h/%h exp=%h/%h/%h", c, memWEnable, memWAddr, memWData, pb[gi], w, pd[gi]);
          end
          tmp = ref_rd(w);
          for (int b = 0; b < 4; b++) if (pb[gi][b]) tmp[8*b +: 8] = pd[gi][8*b +: 8];
          ref_mem[w] = tmp;
        end else begin
          n_cmp++; if ({memWEnable, memRAddr} !== {4'h0, 15'(w)}) begin
            n_bad++; $display("FAIL rnd_load c=%0d got=%h/%h exp=0/%h", c, memWEnable, memRAddr, w);
          end
          exp_rv = gi ? 2'b10 : 2'b01;
          exp_rd = ref_rd(w);
        end
        pend[gi] = 1'b0;
      end else begin
        n_cmp++; if (memWEnable !== 4'h0) begin n_bad++; $display("FAIL rnd_idle_wen c=%0d got=%h exp=0", c, memWEnable); end
      end
      if (gv) last = gi;
      lost1 = (reqValid[1] && !(gv && gi)) ? ((lost1 < MAX_WAIT - 1) ? lost1 + 1 : lost1) : 0;
      @(negedge clk);
    end
    n_cmp++; if (rspValid !== exp_rv) begin n_bad++; $display("FAIL rnd_final got=%b exp=%b", rspValid, exp_rv); end
    reqValid = 2'b00;
  endtask

  initial begin
    for (int i = 0; i < 32768; i++) mem[i] = 32'h0;
    test_reset();
    test_store_load();
    test_byte_enable();
    test_contest();
    test_back_to_back();
    test_reset_mid_load();
    test_random();
    @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
